// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage RV64 pipeline.
//   - Inserts one ID/EX bubble on a load-use hazard.
//   - Flushes IF/ID, ID/EX and EX/MEM when a taken branch resolves in MEM.
//   - Freezes the pipeline while data memory is busy. A redirect seen
//     during the freeze is remembered and applied on the release cycle.
//   - Keeps wrapping stall/flush counters and a sticky memory-timeout flag.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   idex_memread, idex_rd: load flag and destination of the ID/EX instruction
//   ifid_rs1, ifid_rs2   : source registers of the IF/ID instruction
//   ifid_rs2_valid       : IF/ID instruction actually reads rs2
//   branch_taken         : taken branch resolved in EX/MEM
//   mem_busy             : data memory not ready this cycle
//   pc_write, ifid_write : PC and IF/ID register enables
//   ifid_flush, idex_flush, exmem_flush : pipeline register clears
//   pipe_hold            : freeze ID/EX, EX/MEM and MEM/WB
//   stall_cnt, flush_cnt : stall cycles / redirects applied (wrapping)
//   mem_timeout          : sticky flag, memory wait exceeded TIMEOUT cycles
//   state                : RUN=0, LOAD_BUBBLE=1, MEM_WAIT=2

module pipe_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_rs2_valid,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        LOAD_BUBBLE = 2'd1,
        MEM_WAIT    = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic              br_pending_q, br_pending_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              mem_timeout_q;
    logic              stall_inc, flush_inc, timeout_set;
    logic              load_use;

    // rd==x0 never creates a hazard since x0 is never written.
    assign load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) ||
                       (ifid_rs2_valid && (idex_rd == ifid_rs2)));

    // Next-state and Mealy control outputs. Priority outside MEM_WAIT is
    // memory freeze, then redirect, then load-use bubble; the redirect wins
    // over the bubble because the instruction that would stall is flushed.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        pipe_hold    = 1'b0;
        state_d      = RUN;
        br_pending_d = br_pending_q;
        wait_cnt_d   = wait_cnt_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        timeout_set  = 1'b0;

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (state_q)
                MEM_WAIT: begin
                    if (mem_busy) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        pipe_hold    = 1'b1;
                        stall_inc    = 1'b1;
                        br_pending_d = br_pending_q | branch_taken;
                        state_d      = MEM_WAIT;
                        // Saturate at TIMEOUT; waiting goes on after the flag.
                        if (wait_cnt_q == TO_MAX) begin
                            timeout_set = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + TO_W'(1);
                        end
                    end else begin
                        // Release: load-use is deliberately not checked here,
                        // the unfrozen load is re-evaluated next cycle.
                        if (br_pending_q || branch_taken) begin
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                            exmem_flush = 1'b1;
                            flush_inc   = 1'b1;
                        end
                        br_pending_d = 1'b0;
                        wait_cnt_d   = '0;
                        state_d      = RUN;
                    end
                end

                default: begin
                    br_pending_d = 1'b0;
                    if (mem_busy) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        pipe_hold    = 1'b1;
                        stall_inc    = 1'b1;
                        br_pending_d = branch_taken;
                        wait_cnt_d   = TO_W'(1);
                        state_d      = MEM_WAIT;
                    end else if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (load_use && (state_q == RUN)) begin
                        // LOAD_BUBBLE masks lu so one load gets one bubble.
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                        state_d    = LOAD_BUBBLE;
                    end
                end
            endcase
        end
    end

    // State, pending redirect, wait counter, statistics and sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            br_pending_q  <= 1'b0;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            br_pending_q <= br_pending_d;
            wait_cnt_q   <= wait_cnt_d;
            if (stall_inc) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (timeout_set) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = mem_timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl with TIMEOUT=3 and 4-bit counters so the
// timeout and counter wrap are reachable in a short run.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int TO    = 3;

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold}
    localparam logic [5:0] C_RST    = 6'b001110;
    localparam logic [5:0] C_DEF    = 6'b110000;
    localparam logic [5:0] C_FREEZE = 6'b000001;
    localparam logic [5:0] C_REDIR  = 6'b111110;
    localparam logic [5:0] C_BUBBLE = 6'b000100;

    typedef struct packed {
        logic [5:0]       ctrl;
        logic [1:0]       st;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             to;
    } obs_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             idex_memread;
    logic [4:0]       idex_rd;
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             ifid_rs2_valid;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout;
    logic [1:0]       state;

    int n_cmp  = 0;
    int n_fail = 0;

    obs_t  sb_q[$];
    string tag_q[$];

    // Reference model state (current) and its value after the next edge.
    int m_state, m_wait, m_stall, m_flush;
    bit m_pend, m_to;
    int n_state, n_wait, n_stall, n_flush;
    bit n_pend, n_to;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_rs2_valid(ifid_rs2_valid),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, work out what the controller must show this
    // cycle and where the model goes on the next edge, and queue the result.
    task automatic applyStimulus(input string tag, input bit rst, input bit mr,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input bit rs2v,
                                 input bit br, input bit busy);
        obs_t e;
        bit   lu;
        reset = rst; idex_memread = mr; idex_rd = rd; ifid_rs1 = rs1;
        ifid_rs2 = rs2; ifid_rs2_valid = rs2v; branch_taken = br; mem_busy = busy;

        lu = mr && (rd != 5'd0) && ((rd == rs1) || (rs2v && (rd == rs2)));
        n_state = 0; n_pend = m_pend; n_wait = m_wait;
        n_stall = m_stall; n_flush = m_flush; n_to = m_to;

        if (rst) begin
            e.ctrl = C_RST;
            n_pend = 0; n_wait = 0; n_stall = 0; n_flush = 0; n_to = 0;
        end else if (m_state == 2) begin
            if (busy) begin
                e.ctrl = C_FREEZE;
                n_state = 2;
                n_stall = (m_stall + 1) % 16;
                n_pend = m_pend | br;
                if (m_wait == TO) n_to = 1;
                else n_wait = m_wait + 1;
            end else begin
                e.ctrl = (m_pend || br) ? C_REDIR : C_DEF;
                if (m_pend || br) n_flush = (m_flush + 1) % 16;
                n_pend = 0; n_wait = 0;
            end
        end else if (busy) begin
            e.ctrl = C_FREEZE;
            n_state = 2; n_pend = br; n_wait = 1;
            n_stall = (m_stall + 1) % 16;
        end else if (br) begin
            e.ctrl = C_REDIR;
            n_flush = (m_flush + 1) % 16;
        end else if (lu && m_state == 0) begin
            e.ctrl = C_BUBBLE;
            n_state = 1;
            n_stall = (m_stall + 1) % 16;
        end else begin
            e.ctrl = C_DEF;
        end

        e.st    = 2'(m_state);
        e.stall = CNT_W'(m_stall);
        e.flush = CNT_W'(m_flush);
        e.to    = m_to;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs.
    task automatic checkOutput();
        obs_t  a, e;
        string t;
        a = '{ctrl: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold},
              st: state, stall: stall_cnt, flush: flush_cnt, to: mem_timeout};
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("[TB] FAIL scoreboard_empty: observed=%h required=queued entry", a);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            assert (a === e) else begin
                n_fail++;
                $error("[TB] FAIL %s: observed=%h required=%h (ctrl/state/stall/flush/to)", t, a, e);
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h required=%0h", tag, obs, req);
        end
    endtask

    // One full cycle: drive just after posedge, check at negedge, advance model.
    task automatic cycle(input string tag, input bit rst, input bit mr,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit rs2v,
                         input bit br, input bit busy);
        applyStimulus(tag, rst, mr, rd, rs1, rs2, rs2v, br, busy);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        m_state = n_state; m_pend = n_pend; m_wait = n_wait;
        m_stall = n_stall; m_flush = n_flush; m_to = n_to;
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; idex_memread = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        ifid_rs2_valid = 0; branch_taken = 0; mem_busy = 0;
        m_state = 0; m_pend = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 0;
        @(posedge clk); #1;

        cycle("reset_hold", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        idle("after_reset");

        // Load-use via rs1, lu held during the bubble to prove suppression.
        cycle("lu_rs1", 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
        cycle("lu_bubble", 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
        checkValue("stall_after_lu", 32'(stall_cnt), 32'd1);
        idle("lu_done");

        // No hazard: x0 destination, and rs2 match that is not read.
        cycle("rd_zero", 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        cycle("rs2_unused", 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0);
        checkValue("state_no_hazard", 32'(state), 32'd0);
        cycle("lu_rs2", 0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0);
        idle("rs2_bubble");

        // Branch beats a simultaneous load-use.
        cycle("branch_lu", 0, 1, 5'd9, 5'd9, 5'd0, 0, 1, 0);
        checkValue("flush_after_br", 32'(flush_cnt), 32'd1);
        checkValue("stall_after_br", 32'(stall_cnt), 32'd2);

        // Memory wait of 4 cycles, redirect arrives in wait cycle 2.
        cycle("mw1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        cycle("mw2_br", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        cycle("mw3", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        cycle("mw4", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        cycle("mw_release", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        checkValue("stall_after_mw", 32'(stall_cnt), 32'd6);
        checkValue("flush_after_mw", 32'(flush_cnt), 32'd2);

        // Branch taken inside LOAD_BUBBLE.
        cycle("lu_again", 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0);
        cycle("bubble_br", 0, 1, 5'd4, 5'd4, 5'd0, 0, 1, 0);

        // Timeout after 3 MEM_WAIT cycles, flag sticks after release.
        for (int i = 0; i < 6; i++) cycle("to_wait", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        cycle("to_release", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        idle("to_sticky");
        checkValue("timeout_sticky", 32'(mem_timeout), 32'd1);

        // Long wait pushes the 4-bit stall counter through its wrap.
        for (int i = 0; i < 5; i++) cycle("wrap_wait", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        cycle("wrap_release", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        checkValue("stall_wrapped", 32'(stall_cnt), 32'd2);

        // Reset in MEM_WAIT with a redirect pending: it must be discarded.
        cycle("rw1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        cycle("rw2_br", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        cycle("rw_reset", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        cycle("rw_after", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        checkValue("rw_stall_zero", 32'(stall_cnt), 32'd0);
        checkValue("rw_flush_zero", 32'(flush_cnt), 32'd0);
        checkValue("rw_timeout_clr", 32'(mem_timeout), 32'd0);
        idle("final");

        checkValue("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV64 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards and inserts a single ID/EX bubble.
- Applies branch-redirect flushes when a taken branch resolves in the MEM stage.
- Freezes the whole pipeline while data memory is busy, keeps a redirect that arrives during the freeze, and maintains stall/flush counters plus a sticky memory-timeout flag.

Parameters:
- CNT_W, 32: width of stall_cnt and flush_cnt; both counters wrap modulo 2^CNT_W.
- TIMEOUT, 255: number of consecutive MEM_WAIT cycles after which mem_timeout is set.
- TO_W, 8: width of the wait counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- idex_memread  in  1  instruction in ID/EX is a load.
- idex_rd  in  5  destination register of the instruction in ID/EX.
- ifid_rs1  in  5  rs1 of the instruction in IF/ID.
- ifid_rs2  in  5  rs2 of the instruction in IF/ID.
- ifid_rs2_valid  in  1  instruction in IF/ID reads rs2 (R/S/B types).
- branch_taken  in  1  EX/MEM Branch AND zero; registered upstream.
- mem_busy  in  1  data memory not ready this cycle.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID.
- idex_flush  out  1  clear ID/EX (drives its flush input).
- exmem_flush  out  1  clear EX/MEM.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- stall_cnt  out  CNT_W  number of stall cycles.
- flush_cnt  out  CNT_W  number of redirects applied.
- mem_timeout  out  1  sticky error flag.
- state  out  2  RUN=0, LOAD_BUBBLE=1, MEM_WAIT=2.

Behaviour:
- Control outputs are Mealy outputs, combinational from state, br_pending and the current inputs. Counters, flag, state and br_pending are registered.
- Default control values: pc_write=1, ifid_write=1, all flushes=0, pipe_hold=0.
- While reset=1: pc_write=0, ifid_write=0, ifid_flush=idex_flush=exmem_flush=1, pipe_hold=0.
- On the reset edge: state=RUN, br_pending=0, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0. A reset asserted mid-MEM_WAIT discards any pending redirect.
- Load-use condition lu: idex_memread & (idex_rd!=0) & ((idex_rd==ifid_rs1) | (ifid_rs2_valid & idex_rd==ifid_rs2)).
- Priority in RUN and LOAD_BUBBLE: mem_busy > branch_taken > lu (lu only in RUN).
  - mem_busy: pc_write=0, ifid_write=0, pipe_hold=1, no flushes. br_pending<=branch_taken. stall_cnt++, wait_cnt<=1. Next state MEM_WAIT.
  - branch_taken: ifid_flush=idex_flush=exmem_flush=1, pc_write=1 (PC loads the target through the existing mux). flush_cnt++. Next state RUN. The redirect overrides any load-use stall.
  - lu (RUN only): pc_write=0, ifid_write=0, idex_flush=1. stall_cnt++. Next state LOAD_BUBBLE.
  - Otherwise: default values, next state RUN.
- LOAD_BUBBLE: lasts exactly one cycle with lu detection suppressed, so at most one bubble is inserted per load. mem_busy and branch_taken are handled as in RUN.
- MEM_WAIT:
  - While mem_busy=1: freeze outputs as above, stall_cnt++, br_pending<=br_pending|branch_taken, wait_cnt increments and saturates at TIMEOUT. The cycle on which wait_cnt==TIMEOUT sets mem_timeout=1; it stays set until reset. Waiting continues after the timeout.
  - Release cycle (mem_busy=0): if br_pending|branch_taken, apply the redirect outputs and flush_cnt++; otherwise default values. Then br_pending<=0, wait_cnt<=0, next state RUN. Load-use is not checked on the release cycle; the frozen load re-evaluates on the following cycle.
- Each stall or redirect cycle increments its counter by exactly 1. Both counters wrap to 0 after the all-ones value.

Test Plan:
- Load-use, rs1 path: idex_memread=1, idex_rd=5, ifid_rs1=5 in RUN. Required: that cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle state=1 with default outputs; stall_cnt=1.
- No hazard cases: idex_rd=0 with ifid_rs1=0, and separately rs2 match with ifid_rs2_valid=0. Required: no stall, state stays 0.
- Branch: branch_taken=1 for one cycle in RUN, lu also true. Required: all three flushes=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait with redirect: mem_busy=1 for 4 cycles, branch_taken pulsed in wait cycle 2. Required: pipe_hold=1 for 4 cycles, stall_cnt=4, then on the release cycle all flushes=1 and flush_cnt=1.
- Timeout: TIMEOUT=3, mem_busy held for 6 cycles. Required: mem_timeout rises after the 3rd wait cycle and stays 1 after release until reset.
- Reset mid-MEM_WAIT with br_pending=1. Required: state=0, counters=0, no redirect after reset; during reset all flushes=1 and pc_write=0.
